seg7_capture: RTL and testbench
===============================

# seg7_capture

Sequential receiver for the multiplexed 7-segment bus that the display path produces: it samples the active-low segment lines and active-low digit selects, waits for a stable scan slot, and decodes the segment pattern back to a 4-bit hex value. Each capture is emitted as a valid/ready stream beat of digit index and nibble, and also stored in a per-digit register bank. The block sits on board-level loopback and self-test paths to prove display content without a camera.

## Interface
- `NUM_DIGITS`, default 4: number of multiplexed digits; range 1..8.
- `STABLE_CYCLES`, default 16: consecutive identical samples required before a capture; range 1..65535.
- `clk` in 1: single clock.
- `rst_n` in 1: one clock; reset is asynchronous and active-low.
- `seg_n` in 7: segment lines, active-low, bit0=a … bit6=g; asynchronous to `clk`.
- `dig_n` in NUM_DIGITS: digit selects, active-low; asynchronous to `clk`.
- `out_valid` out 1: capture beat available.
- `out_ready` in 1: consumer accepts the beat.
- `out_idx` out $clog2(NUM_DIGITS) (min 1): digit index of the beat.
- `out_nibble` out 4: decoded value; 4'h0 when `out_err`.
- `out_err` out 1: pattern not one of the 16 legal glyphs; qualified by `out_valid`.
- `digits` out 4*NUM_DIGITS: last good nibble per digit; digit i at [4i+3:4i].
- `ovf` out 1: sticky; a capture was dropped while a beat was pending.
- `ovf_clr` in 1: synchronous clear of `ovf`.
- `err_count` out 8: saturating illegal-pattern count (see Configuration).

## Operation
- Two-flop synchronizer on `seg_n` and `dig_n`; all logic uses synchronized copies.
- Legal glyphs (`seg_n`, active-low): 0=40 1=79 2=24 3=30 4=19 5=12 6=02 7=78 8=00 9=10 A=08 b=03 C=46 d=21 E=06 F=0E (hex).
- FSM states:
  - IDLE: `dig_n` not exactly one bit low. On one-hot-low, go to SETTLE with the counter at 1.
  - SETTLE: the counter increments while `{dig_n,seg_n}` equals the previous sample. Any change restarts at 1, or goes to IDLE if no longer one-hot. When the counter reaches STABLE_CYCLES, go to CAPTURE.
  - CAPTURE: one cycle. Decode, then load the output register if free; otherwise drop the beat and set `ovf`. A legal pattern updates `digits[idx]`. Go to HOLD.
  - HOLD: no re-capture. Any change of `{dig_n,seg_n}` returns to IDLE/SETTLE handling, which re-arms the FSM.
- Output register: `out_valid` rises on load and falls on the cycle after `out_valid&&out_ready`. `out_idx`, `out_nibble` and `out_err` are stable while valid. Simultaneous accept and new capture loads the new beat without setting `ovf`.
- `ovf_clr` together with a drop in the same cycle leaves `ovf`=1.
- Reset values: `out_valid`=0, `out_idx`=0, `out_nibble`=0, `out_err`=0, `digits`=0, `ovf`=0, `err_count`=0, FSM=IDLE, counter=0, synchronizers all-ones (blank, no digit).

## Timing
- Input change to `out_valid` rising: 2 (sync) + STABLE_CYCLES + 1 cycles.
- `digits` updates on the same edge that `out_valid` rises.
- Throughput: at most one capture per digit activation.
- Reset mid-capture: all state returns to reset values immediately; a pending beat is lost.

## Configuration
- `SEG7_ERR_COUNT_EN` defined: `err_count` increments on each CAPTURE with an illegal pattern (dropped or not) and saturates at 8'hFF. `ovf_clr` also clears it.
- Not defined: `err_count` is tied to 8'h00 and the counter logic is absent; all other behaviour is identical.

## Structure
- `seg7_pkg` holds the 16 glyph constants, `seg7_state_t` enum (IDLE, SETTLE, CAPTURE, HOLD), and the `SEG7_BLANK`=7'h7F constant.
- Sub-module `seg7_glyph_decode`: combinational pattern→{err, nibble} lookup, instantiated once.

## Test plan
- `dig_n`=4'b1110, `seg_n`=7'h24 held, STABLE_CYCLES=16, `out_ready`=1 -> one beat at cycle 19: idx 0, nibble 2, err 0; `digits[3:0]`=2.
- Scan all 16 glyphs on digit 3 -> 16 beats, nibbles 0..F in order, `err_count`=0.
- `seg_n`=7'h7F (blank) on digit 1 -> beat with err=1, nibble 0; `digits[7:4]` unchanged; `err_count`=1 when `SEG7_ERR_COUNT_EN` is defined, 0 when not.
- `out_ready`=0, two digit activations -> first beat held, second dropped, `ovf`=1; `ovf_clr` pulse -> `ovf`=0.
- `seg_n` toggled every 8 cycles with STABLE_CYCLES=16 -> no beat; then held -> exactly one beat.
- Two `dig_n` bits low -> no capture. Assert `rst_n` during SETTLE -> all outputs at reset values on the next cycle.

Source files
------------

// File: rtl/seg7_pkg.sv
// Shared types and glyph constants for the 7-segment capture path.
package seg7_pkg;

  localparam int unsigned SEG_W  = 7;
  localparam int unsigned NIB_W  = 4;
  localparam int unsigned CNT_W  = 16;
  localparam int unsigned ERRC_W = 8;

  localparam logic [SEG_W-1:0] SEG7_BLANK = 7'h7F;

  // Active-low segment patterns, bit0=a .. bit6=g
  localparam logic [SEG_W-1:0] GLYPH_0 = 7'h40;
  localparam logic [SEG_W-1:0] GLYPH_1 = 7'h79;
  localparam logic [SEG_W-1:0] GLYPH_2 = 7'h24;
  localparam logic [SEG_W-1:0] GLYPH_3 = 7'h30;
  localparam logic [SEG_W-1:0] GLYPH_4 = 7'h19;
  localparam logic [SEG_W-1:0] GLYPH_5 = 7'h12;
  localparam logic [SEG_W-1:0] GLYPH_6 = 7'h02;
  localparam logic [SEG_W-1:0] GLYPH_7 = 7'h78;
  localparam logic [SEG_W-1:0] GLYPH_8 = 7'h00;
  localparam logic [SEG_W-1:0] GLYPH_9 = 7'h10;
  localparam logic [SEG_W-1:0] GLYPH_A = 7'h08;
  localparam logic [SEG_W-1:0] GLYPH_B = 7'h03;
  localparam logic [SEG_W-1:0] GLYPH_C = 7'h46;
  localparam logic [SEG_W-1:0] GLYPH_D = 7'h21;
  localparam logic [SEG_W-1:0] GLYPH_E = 7'h06;
  localparam logic [SEG_W-1:0] GLYPH_F = 7'h0E;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SETTLE  = 2'd1,
    CAPTURE = 2'd2,
    HOLD    = 2'd3
  } seg7_state_t;

  typedef struct packed {
    logic             err;
    logic [NIB_W-1:0] nibble;
  } seg7_dec_t;

endpackage

// File: rtl/seg7_glyph_decode.sv
// Combinational segment-pattern to hex-nibble lookup; unknown patterns flag err with nibble 0.
module seg7_glyph_decode
  import seg7_pkg::*;
(
  input  logic [SEG_W-1:0] seg_n,
  output seg7_dec_t        dec_c
);

  always_comb begin
    dec_c.err    = 1'b0;
    dec_c.nibble = 4'h0;
    case (seg_n)
      GLYPH_0: dec_c.nibble = 4'h0;
      GLYPH_1: dec_c.nibble = 4'h1;
      GLYPH_2: dec_c.nibble = 4'h2;
      GLYPH_3: dec_c.nibble = 4'h3;
      GLYPH_4: dec_c.nibble = 4'h4;
      GLYPH_5: dec_c.nibble = 4'h5;
      GLYPH_6: dec_c.nibble = 4'h6;
      GLYPH_7: dec_c.nibble = 4'h7;
      GLYPH_8: dec_c.nibble = 4'h8;
      GLYPH_9: dec_c.nibble = 4'h9;
      GLYPH_A: dec_c.nibble = 4'hA;
      GLYPH_B: dec_c.nibble = 4'hB;
      GLYPH_C: dec_c.nibble = 4'hC;
      GLYPH_D: dec_c.nibble = 4'hD;
      GLYPH_E: dec_c.nibble = 4'hE;
      GLYPH_F: dec_c.nibble = 4'hF;
      default: dec_c.err    = 1'b1;
    endcase
  end

endmodule

// File: rtl/seg7_capture.sv
// Multiplexed 7-segment bus receiver: waits for a stable scan slot, decodes it and emits a stream beat.
// Define SEG7_ERR_COUNT_EN to build the saturating illegal-pattern counter on err_count.
module seg7_capture
  import seg7_pkg::*;
#(
  parameter  int unsigned NUM_DIGITS    = 4,
  parameter  int unsigned STABLE_CYCLES = 16,
  localparam int unsigned IDX_W         = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [SEG_W-1:0]          seg_n,
  input  logic [NUM_DIGITS-1:0]     dig_n,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [IDX_W-1:0]          out_idx,
  output logic [NIB_W-1:0]          out_nibble,
  output logic                      out_err,
  output logic [4*NUM_DIGITS-1:0]   digits,
  output logic                      ovf,
  input  logic                      ovf_clr,
  output logic [ERRC_W-1:0]         err_count
);

  localparam int unsigned SMP_W = NUM_DIGITS + SEG_W;
  localparam logic [CNT_W-1:0] STABLE_C = CNT_W'(STABLE_CYCLES);

  logic [SEG_W-1:0]      seg_s1, seg_s2;
  logic [NUM_DIGITS-1:0] dig_s1, dig_s2;
  logic [SMP_W-1:0]      smp_c, prev, hold_ref;
  logic [CNT_W-1:0]      cnt, cnt_inc_c;
  logic [IDX_W-1:0]      idx_c, cap_idx;
  logic [3:0]            low_cnt_c;
  logic                  onehot_c;
  seg7_state_t           state, arm_state_c;
  logic [CNT_W-1:0]      arm_cnt_c;
  seg7_dec_t             dec_c;
  logic                  cap_c, load_c, drop_c;

  // Two-flop synchronizers; reset to blank with no digit selected
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      seg_s1 <= '1;
      seg_s2 <= '1;
      dig_s1 <= '1;
      dig_s2 <= '1;
    end else begin
      seg_s1 <= seg_n;
      seg_s2 <= seg_s1;
      dig_s1 <= dig_n;
      dig_s2 <= dig_s1;
    end
  end

  assign smp_c = {dig_s2, seg_s2};

  // Exactly-one-low detection and index of the selected digit
  always_comb begin
    low_cnt_c = 4'd0;
    idx_c     = '0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (!dig_s2[i]) begin
        low_cnt_c = low_cnt_c + 4'd1;
        idx_c     = IDX_W'(i);
      end
    end
    onehot_c = (low_cnt_c == 4'd1);
  end

  // Where a fresh sample leads: start settling at count 1, or straight to capture when one sample suffices
  always_comb begin
    cnt_inc_c   = cnt + CNT_W'(1);
    arm_state_c = IDLE;
    arm_cnt_c   = '0;
    if (onehot_c) begin
      arm_cnt_c   = CNT_W'(1);
      arm_state_c = (STABLE_C <= CNT_W'(1)) ? CAPTURE : SETTLE;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      cnt      <= '0;
      cap_idx  <= '0;
      prev     <= '1;
      hold_ref <= '1;
    end else begin
      prev <= smp_c;
      case (state)
        IDLE: begin
          state   <= arm_state_c;
          cnt     <= arm_cnt_c;
          cap_idx <= idx_c;
        end
        SETTLE: begin
          if (smp_c != prev) begin
            state   <= arm_state_c;
            cnt     <= arm_cnt_c;
            cap_idx <= idx_c;
          end else begin
            cnt <= cnt_inc_c;
            if (cnt_inc_c >= STABLE_C) state <= CAPTURE;
          end
        end
        CAPTURE: begin
          // prev still holds the sample that satisfied the stability window
          hold_ref <= prev;
          state    <= HOLD;
        end
        HOLD: begin
          if (smp_c != hold_ref) begin
            state   <= arm_state_c;
            cnt     <= arm_cnt_c;
            cap_idx <= idx_c;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  seg7_glyph_decode u_decode (
    .seg_n (prev[SEG_W-1:0]),
    .dec_c (dec_c)
  );

  assign cap_c  = (state == CAPTURE);
  assign load_c = cap_c && (!out_valid || out_ready);
  assign drop_c = cap_c && out_valid && !out_ready;

  // Output beat register and per-digit bank
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid  <= 1'b0;
      out_idx    <= '0;
      out_nibble <= '0;
      out_err    <= 1'b0;
      digits     <= '0;
    end else begin
      if (load_c) begin
        out_valid  <= 1'b1;
        out_idx    <= cap_idx;
        out_nibble <= dec_c.nibble;
        out_err    <= dec_c.err;
      end else if (out_valid && out_ready) begin
        out_valid <= 1'b0;
      end
      if (cap_c && !dec_c.err) begin
        for (int i = 0; i < NUM_DIGITS; i++) begin
          if (cap_idx == IDX_W'(i)) digits[4*i +: 4] <= dec_c.nibble;
        end
      end
    end
  end

  // Sticky overflow; a drop in the same cycle beats the clear
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ovf <= 1'b0;
    end else if (drop_c) begin
      ovf <= 1'b1;
    end else if (ovf_clr) begin
      ovf <= 1'b0;
    end
  end

`ifdef SEG7_ERR_COUNT_EN
  logic [ERRC_W-1:0] err_cnt;
  logic              err_hit_c;

  assign err_hit_c = cap_c && dec_c.err;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_cnt <= '0;
    end else if (ovf_clr) begin
      err_cnt <= err_hit_c ? ERRC_W'(1) : '0;
    end else if (err_hit_c && (err_cnt != '1)) begin
      err_cnt <= err_cnt + ERRC_W'(1);
    end
  end

  assign err_count = err_cnt;
`else
  assign err_count = '0;
`endif

endmodule

// File: tb/tb_seg7_capture.sv
// Directed plus randomized bench for seg7_capture against a table-driven reference model.
module tb_seg7_capture;

  localparam int ND = 4;
  localparam int SC = 16;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [6:0]  seg_n;
  logic [3:0]  dig_n;
  logic        out_valid, out_ready;
  logic [1:0]  out_idx;
  logic [3:0]  out_nibble;
  logic        out_err;
  logic [15:0] digits;
  logic        ovf, ovf_clr;
  logic [7:0]  err_count;

  int ncmp  = 0;
  int nfail = 0;

  logic [6:0] glyph [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                             7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

  typedef struct {
    int idx;
    int nib;
    int err;
  } beat_t;

  beat_t beats[$];
  int    md [ND];
  int    mec;

  seg7_capture #(.NUM_DIGITS(ND), .STABLE_CYCLES(SC)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .seg_n      (seg_n),
    .dig_n      (dig_n),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_idx    (out_idx),
    .out_nibble (out_nibble),
    .out_err    (out_err),
    .digits     (digits),
    .ovf        (ovf),
    .ovf_clr    (ovf_clr),
    .err_count  (err_count)
  );

  always #5 clk = ~clk;

  // Record every accepted beat, sampled mid-cycle
  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready)
      beats.push_back('{int'(out_idx), int'(out_nibble), int'(out_err)});
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    ncmp++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic ref_decode(input logic [6:0] s, output int err, output int nib);
    err = 1;
    nib = 0;
    for (int k = 0; k < 16; k++) begin
      if (glyph[k] == s) begin
        err = 0;
        nib = k;
      end
    end
  endtask

  function automatic logic [31:0] ref_digits();
    logic [31:0] p = '0;
    for (int k = 0; k < ND; k++) p = p | (32'(md[k] & 15) << (4 * k));
    return p;
  endfunction

  task automatic ref_capture(input int d, input logic [6:0] s, output int err, output int nib);
    ref_decode(s, err, nib);
    if (err == 0) md[d] = nib;
`ifdef SEG7_ERR_COUNT_EN
    if (err != 0 && mec < 255) mec++;
`endif
  endtask

  // Activate digit d with pattern s long enough to capture, then blank the bus
  task automatic show(input int d, input logic [6:0] s);
    dig_n = ~(4'(1 << d));
    seg_n = s;
    cycles(SC + 8);
    dig_n = 4'hF;
    seg_n = 7'h7F;
    cycles(4);
  endtask

  task automatic expect_one(input int d, input logic [6:0] s, input string tag);
    int    err, nib;
    beat_t b;
    ref_capture(d, s, err, nib);
    check({tag, "_beats"}, beats.size(), 1);
    if (beats.size() > 0) begin
      b = beats.pop_front();
      check({tag, "_idx"}, b.idx, d);
      check({tag, "_nib"}, b.nib, nib);
      check({tag, "_err"}, b.err, err);
    end
    check({tag, "_digits"}, digits, ref_digits());
    check({tag, "_errcnt"}, err_count, mec);
    beats.delete();
  endtask

  initial begin
    int          cyc, d, err, nib;
    logic [6:0]  s;
    beat_t       b;

    rst_n = 1'b0; seg_n = 7'h7F; dig_n = 4'hF; out_ready = 1'b0; ovf_clr = 1'b0;
    for (int k = 0; k < ND; k++) md[k] = 0;
    mec = 0;
    cycles(3);
    check("rst_valid",  out_valid,  0);
    check("rst_idx",    out_idx,    0);
    check("rst_nibble", out_nibble, 0);
    check("rst_err",    out_err,    0);
    check("rst_digits", digits,     0);
    check("rst_ovf",    ovf,        0);
    check("rst_errcnt", err_count,  0);

    // Latency from input change to out_valid
    rst_n = 1'b1; out_ready = 1'b1; dig_n = 4'b1110; seg_n = 7'h24;
    cyc = 0;
    while (!out_valid && cyc < 60) begin
      @(posedge clk);
      cyc++;
      @(negedge clk);
    end
    check("t1_latency", cyc, 2 + SC + 1);
    check("t1_idx",     out_idx,      0);
    check("t1_nib",     out_nibble,   2);
    check("t1_err",     out_err,      0);
    check("t1_dig0",    digits[3:0],  2);
    md[0] = 2;
    dig_n = 4'hF; seg_n = 7'h7F;
    cycles(4);
    beats.delete();

    // All glyphs in order on digit 3
    for (int g = 0; g < 16; g++) show(3, glyph[g]);
    check("scan_beats", beats.size(), 16);
    for (int g = 0; g < 16; g++) begin
      if (beats.size() > 0) begin
        b = beats.pop_front();
        check("scan_idx", b.idx, 3);
        check("scan_nib", b.nib, g);
        check("scan_err", b.err, 0);
      end
    end
    md[3] = 15;
    check("scan_digits", digits, ref_digits());
    check("scan_errcnt", err_count, mec);
    beats.delete();

    // Blank pattern is illegal and leaves the bank untouched
    show(1, 7'h7F);
    expect_one(1, 7'h7F, "blank");

    // Random activations: mostly legal glyphs, some arbitrary patterns
    repeat (24) begin
      d = $urandom_range(0, ND - 1);
      if ($urandom_range(0, 3) == 0) s = 7'($urandom);
      else                           s = glyph[$urandom_range(0, 15)];
      show(d, s);
      expect_one(d, s, "rand");
    end

    // Backpressure: first beat held, second dropped, overflow flagged
    out_ready = 1'b0;
    show(0, 7'h12);
    show(2, 7'h78);
    ref_capture(0, 7'h12, err, nib);
    ref_capture(2, 7'h78, err, nib);
    check("bp_valid",  out_valid,  1);
    check("bp_idx",    out_idx,    0);
    check("bp_nib",    out_nibble, 5);
    check("bp_ovf",    ovf,        1);
    check("bp_digits", digits,     ref_digits());
    check("bp_beats",  beats.size(), 0);
    ovf_clr = 1'b1;
    cycles(1);
    ovf_clr = 1'b0;
    mec = 0;
    check("bp_ovf_clr", ovf, 0);
    out_ready = 1'b1;
    cycles(2);
    check("bp_drain", out_valid, 0);
    beats.delete();

    // Pattern changing faster than the stability window never captures
    dig_n = 4'b1011;
    for (int i = 0; i < 10; i++) begin
      seg_n = (i % 2 != 0) ? 7'h24 : 7'h30;
      cycles(8);
    end
    check("toggle_none", beats.size(), 0);
    seg_n = 7'h30;
    cycles(SC + 8);
    dig_n = 4'hF; seg_n = 7'h7F;
    cycles(4);
    expect_one(2, 7'h30, "toggle_hold");

    // Two selects low at once is not a scan slot
    dig_n = 4'b1100; seg_n = 7'h24;
    cycles(40);
    check("multi_beats", beats.size(), 0);
    check("multi_valid", out_valid, 0);
    dig_n = 4'hF; seg_n = 7'h7F;
    cycles(4);

    // Reset while settling
    dig_n = 4'b1110; seg_n = 7'h40;
    cycles(10);
    rst_n = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check("mrst_valid",  out_valid,  0);
    check("mrst_idx",    out_idx,    0);
    check("mrst_nibble", out_nibble, 0);
    check("mrst_err",    out_err,    0);
    check("mrst_digits", digits,     0);
    check("mrst_ovf",    ovf,        0);
    check("mrst_errcnt", err_count,  0);
    for (int k = 0; k < ND; k++) md[k] = 0;
    mec = 0;
    beats.delete();
    rst_n = 1'b1;
    cycles(SC + 8);
    dig_n = 4'hF; seg_n = 7'h7F;
    cycles(4);
    expect_one(0, 7'h40, "post_rst");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
    $finish;
  end

endmodule
